// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// R-type funct decoder: ALU operation plus a flag for unsupported funct codes.
module alu_dec
  import mctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_illegal  = 1'b0;
    case (i_funct)
      FN_ADD:  o_alu_ctrl = ALU_ADD;
      FN_SUB:  o_alu_ctrl = ALU_SUB;
      FN_AND:  o_alu_ctrl = ALU_AND;
      FN_OR:   o_alu_ctrl = ALU_OR;
      FN_SLT:  o_alu_ctrl = ALU_SLT;
      default: o_illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath with retired-instruction counter.
// Define MCTRL_MEM_WAIT_EN to make FETCH/MEMRD/MEMWR wait on mem_ready.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_en,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_ctrl_sig,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output state_t           dbg_state
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic             w_mem_ok;
  logic             w_ir_write, w_pc_write, w_branch, w_mem_write;
  logic             w_reg_write, w_illegal, w_retire;
  logic [2:0]       w_fn_alu;
  logic             w_fn_illegal;

  // mem_ready is the ready half of a memory handshake: a memory-access state
  // completes (and its write enables count as accepted) on the edge where it is high.
`ifdef MCTRL_MEM_WAIT_EN
  assign w_mem_ok = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_ok = 1'b1;
`endif

  alu_dec u_alu_dec (
    .i_funct    (funct),
    .o_alu_ctrl (w_fn_alu),
    .o_illegal  (w_fn_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_retire     = 1'b0;
    iord         = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REG;
    pc_src       = PCSRC_ALU;
    alu_ctrl_sig = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        w_ir_write = w_mem_ok;
        w_pc_write = w_mem_ok;
        if (w_mem_ok) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEXEC;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (w_mem_ok) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        w_mem_write = 1'b1;
        if (w_mem_ok) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_src_a    = 1'b1;
        alu_ctrl_sig = w_fn_alu;
        w_illegal    = w_fn_illegal;
        w_next       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_ctrl_sig = ALU_SUB;
        pc_src       = PCSRC_ALUOUT;
        w_branch     = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        w_pc_write = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_count <= '0;
    else if (w_retire) r_count <= r_count + CNT_W'(1);
  end

  // Write enables are masked by reset so an abandoned instruction cannot commit.
  assign ir_write    = w_ir_write & ~reset;
  assign pc_en       = (w_pc_write | (w_branch & zero)) & ~reset;
  assign mem_write   = w_mem_write & ~reset;
  assign reg_write   = w_reg_write & ~reset;
  assign illegal     = w_illegal & ~reset;
  assign instr_count = r_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a random instruction stream.
module tb_multicycle_ctrl;
  import mctrl_pkg::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode, funct;
  logic             zero, mem_ready;
  logic             iord, mem_write, ir_write, pc_en, reg_dst, mem_to_reg, reg_write;
  logic             alu_src_a, illegal;
  logic [1:0]       alu_src_b, pc_src;
  logic [2:0]       alu_ctrl_sig;
  logic [CNT_W-1:0] instr_count;
  state_t           dbg_state;

  int               total = 0;
  int               bad = 0;
  logic [CNT_W-1:0] m_count = '0;

  // Per-instruction observation: bit i of each mask is cycle i+1 of the instruction.
  typedef struct {
    logic [7:0]       irw, rw, mw, pcen, ill, m2r, rdst;
    logic [2:0]       alu3;
    logic [1:0]       pcsrc3;
    logic [CNT_W-1:0] cnt1;
    logic [31:0]      st;
    int               len;
  } obs_t;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_en(pc_en), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_ctrl_sig(alu_ctrl_sig), .illegal(illegal), .instr_count(instr_count),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  // Reference: instruction-level timing table (which cycle of an instruction does what).
  function automatic obs_t model(input logic [5:0] op, input logic [5:0] fn, input logic z);
    obs_t e;
    e.irw = 8'h01; e.pcen = 8'h01; e.rw = 8'h00; e.mw = 8'h00; e.ill = 8'h00;
    e.m2r = 8'h00; e.rdst = 8'h00; e.alu3 = ALU_ADD; e.pcsrc3 = PCSRC_ALU;
    e.cnt1 = '0; e.st = '0;
    case (op)
      OP_LW:   begin e.len = 5; e.rw = 8'h10; e.m2r = 8'h10; end
      OP_SW:   begin e.len = 4; e.mw = 8'h08; end
      OP_ADDI: begin e.len = 4; e.rw = 8'h08; end
      OP_RTYPE: begin
        e.len = 4; e.rw = 8'h08; e.rdst = 8'h08;
        case (fn)
          FN_ADD: e.alu3 = 3'b010;
          FN_SUB: e.alu3 = 3'b110;
          FN_AND: e.alu3 = 3'b000;
          FN_OR:  e.alu3 = 3'b001;
          FN_SLT: e.alu3 = 3'b111;
          default: begin e.alu3 = 3'b010; e.ill = 8'h04; end
        endcase
      end
      OP_BEQ: begin
        e.len = 3; e.alu3 = 3'b110; e.pcsrc3 = 2'b01;
        if (z) e.pcen = 8'h05;
      end
      OP_J:    begin e.len = 3; e.pcsrc3 = 2'b10; e.pcen = 8'h05; end
      default: begin e.len = 2; e.ill = 8'h02; end
    endcase
    return e;
  endfunction

  // Driver: entered #1 after the edge that puts the DUT in FETCH; leaves in the same condition.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int len, output obs_t o);
    opcode = op; funct = fn; zero = z;
    o.irw = '0; o.rw = '0; o.mw = '0; o.pcen = '0; o.ill = '0; o.m2r = '0; o.rdst = '0;
    o.alu3 = '0; o.pcsrc3 = '0; o.cnt1 = '0; o.st = '0; o.len = len;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      o.irw[i] = ir_write;   o.rw[i] = reg_write;  o.mw[i] = mem_write;
      o.pcen[i] = pc_en;     o.ill[i] = illegal;   o.m2r[i] = mem_to_reg;
      o.rdst[i] = reg_dst;   o.st[4*i +: 4] = dbg_state;
      if (i == 0) o.cnt1 = instr_count;
      if (i == 2) begin o.alu3 = alu_ctrl_sig; o.pcsrc3 = pc_src; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; opcode = OP_LW; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    total++; if (dbg_state !== S_FETCH) begin bad++; $display("FAIL reset state got=%0d exp=%0d", dbg_state, S_FETCH); end
    total++; if (instr_count !== '0) begin bad++; $display("FAIL reset count got=%0d exp=0", instr_count); end
    total++; if ({ir_write, pc_en, mem_write, reg_write, illegal} !== 5'b0) begin bad++; $display("FAIL reset enables got=%b exp=00000", {ir_write, pc_en, mem_write, reg_write, illegal}); end
    total++; if ({alu_src_b, alu_ctrl_sig} !== 5'b01010) begin bad++; $display("FAIL reset srcb/alu got=%b exp=01010", {alu_src_b, alu_ctrl_sig}); end
    total++; if ({iord, reg_dst, mem_to_reg, alu_src_a, pc_src} !== 6'b0) begin bad++; $display("FAIL reset misc got=%b exp=000000", {iord, reg_dst, mem_to_reg, alu_src_a, pc_src}); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_lw;
    obs_t e, o;
    logic [19:0] seq;
    e = model(OP_LW, 6'd0, 1'b0);
    run_instr(OP_LW, 6'd0, 1'b0, e.len, o);
    seq = {S_MEMWB, S_MEMRD, S_MEMADR, S_DECODE, S_FETCH};
    total++; if (o.st[19:0] !== seq) begin bad++; $display("FAIL lw states got=%h exp=%h", o.st[19:0], seq); end
    total++; if (o.rw !== e.rw) begin bad++; $display("FAIL lw reg_write got=%b exp=%b", o.rw, e.rw); end
    total++; if (o.m2r !== e.m2r) begin bad++; $display("FAIL lw mem_to_reg got=%b exp=%b", o.m2r, e.m2r); end
    total++; if (o.cnt1 !== m_count) begin bad++; $display("FAIL lw count_before got=%0d exp=%0d", o.cnt1, m_count); end
    m_count++;
    @(negedge clk);
    total++; if (instr_count !== m_count) begin bad++; $display("FAIL lw count_after got=%0d exp=%0d", instr_count, m_count); end
    @(posedge clk); #1;
    // DUT has now left FETCH; finish that fetch with a jump so the next test starts cleanly.
    opcode = OP_J;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_count++;
  endtask

  task automatic test_rtype;
    obs_t e, o;
    e = model(OP_RTYPE, FN_SUB, 1'b0);
    run_instr(OP_RTYPE, FN_SUB, 1'b0, e.len, o);
    total++; if (o.alu3 !== 3'b110) begin bad++; $display("FAIL sub alu_ctrl got=%b exp=110", o.alu3); end
    total++; if (o.rdst !== e.rdst || o.rw !== e.rw) begin bad++; $display("FAIL sub writeback got=%b/%b exp=%b/%b", o.rdst, o.rw, e.rdst, e.rw); end
    total++; if (o.cnt1 !== m_count) begin bad++; $display("FAIL sub count got=%0d exp=%0d", o.cnt1, m_count); end
    m_count++;
    e = model(OP_RTYPE, 6'b111111, 1'b0);
    run_instr(OP_RTYPE, 6'b111111, 1'b0, e.len, o);
    total++; if (o.ill !== 8'h04) begin bad++; $display("FAIL badfunct illegal got=%b exp=00000100", o.ill); end
    total++; if (o.rw !== e.rw) begin bad++; $display("FAIL badfunct reg_write got=%b exp=%b", o.rw, e.rw); end
    m_count++;
  endtask

  task automatic test_beq;
    obs_t e, o;
    for (int z = 1; z >= 0; z--) begin
      e = model(OP_BEQ, 6'd0, z[0]);
      run_instr(OP_BEQ, 6'd0, z[0], e.len, o);
      total++; if (o.pcen !== e.pcen) begin bad++; $display("FAIL beq z=%0d pc_en got=%b exp=%b", z, o.pcen, e.pcen); end
      total++; if (o.pcsrc3 !== 2'b01) begin bad++; $display("FAIL beq z=%0d pc_src got=%b exp=01", z, o.pcsrc3); end
      total++; if (o.st[11:0] !== {S_BRANCH, S_DECODE, S_FETCH}) begin bad++; $display("FAIL beq z=%0d states got=%h", z, o.st[11:0]); end
      m_count++;
    end
  endtask

  task automatic test_illegal_op;
    obs_t e, o;
    e = model(6'b111111, 6'd0, 1'b0);
    run_instr(6'b111111, 6'd0, 1'b0, e.len, o);
    total++; if (o.ill !== 8'h02) begin bad++; $display("FAIL illop illegal got=%b exp=00000010", o.ill); end
    e = model(OP_J, 6'd0, 1'b0);
    run_instr(OP_J, 6'd0, 1'b0, e.len, o);
    total++; if (o.st[3:0] !== S_FETCH) begin bad++; $display("FAIL illop refetch got=%0d exp=%0d", o.st[3:0], S_FETCH); end
    total++; if (o.cnt1 !== m_count) begin bad++; $display("FAIL illop count got=%0d exp=%0d", o.cnt1, m_count); end
    total++; if (o.pcen !== e.pcen) begin bad++; $display("FAIL j pc_en got=%b exp=%b", o.pcen, e.pcen); end
    m_count++;
  endtask

  task automatic test_reset_mid;
    opcode = OP_SW; funct = '0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); @(posedge clk); #1; end
    @(negedge clk);
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rstmid pre mem_write got=%b exp=1", mem_write); end
    #2 reset = 1'b1;
    #1;
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rstmid mem_write got=%b exp=0", mem_write); end
    total++; if (dbg_state !== S_FETCH) begin bad++; $display("FAIL rstmid state got=%0d exp=%0d", dbg_state, S_FETCH); end
    total++; if (instr_count !== '0) begin bad++; $display("FAIL rstmid count got=%0d exp=0", instr_count); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (ir_write !== 1'b0 || pc_en !== 1'b0) begin bad++; $display("FAIL rstmid held ir/pc got=%b%b exp=00", ir_write, pc_en); end
    @(posedge clk); #1;
    reset = 1'b0;
    m_count = '0;
  endtask

`ifdef MCTRL_MEM_WAIT_EN
  task automatic test_mem_wait;
    int mw_cycles;
    mw_cycles = 0;
    opcode = OP_SW; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); @(posedge clk); #1; end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      @(negedge clk);
      if (mem_write) mw_cycles++;
      @(posedge clk); #1;
    end
    total++; if (mw_cycles != 3) begin bad++; $display("FAIL wait mem_write cycles got=%0d exp=3", mw_cycles); end
    total++; if (dbg_state !== S_FETCH) begin bad++; $display("FAIL wait sw end state got=%0d exp=%0d", dbg_state, S_FETCH); end
    m_count++;
    mem_ready = 1'b0;
    @(negedge clk);
    total++; if (ir_write !== 1'b0 || pc_en !== 1'b0) begin bad++; $display("FAIL wait held fetch ir/pc got=%b%b exp=00", ir_write, pc_en); end
    total++; if (instr_count !== m_count) begin bad++; $display("FAIL wait count got=%0d exp=%0d", instr_count, m_count); end
    @(posedge clk); #1;
    total++; if (dbg_state !== S_FETCH) begin bad++; $display("FAIL wait fetch hold got=%0d exp=%0d", dbg_state, S_FETCH); end
    mem_ready = 1'b1;
  endtask
`endif

  task automatic test_random;
    obs_t e, o;
    logic [5:0] op, fn;
    logic z;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 6))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_RTYPE;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        default: begin
          op = 6'($urandom_range(0, 63));
          if (is_legal_op(op)) op = 6'b010001;
        end
      endcase
      case ($urandom_range(0, 5))
        0: fn = FN_ADD;
        1: fn = FN_SUB;
        2: fn = FN_AND;
        3: fn = FN_OR;
        4: fn = FN_SLT;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      z = 1'($urandom_range(0, 1));
      e = model(op, fn, z);
      run_instr(op, fn, z, e.len, o);
      total++; if (o.st[3:0] !== S_FETCH) begin bad++; $display("FAIL rand n=%0d start_state got=%0d exp=%0d", n, o.st[3:0], S_FETCH); end
      total++; if (o.irw !== e.irw) begin bad++; $display("FAIL rand n=%0d op=%b ir_write got=%b exp=%b", n, op, o.irw, e.irw); end
      total++; if (o.rw !== e.rw) begin bad++; $display("FAIL rand n=%0d op=%b reg_write got=%b exp=%b", n, op, o.rw, e.rw); end
      total++; if (o.mw !== e.mw) begin bad++; $display("FAIL rand n=%0d op=%b mem_write got=%b exp=%b", n, op, o.mw, e.mw); end
      total++; if (o.pcen !== e.pcen) begin bad++; $display("FAIL rand n=%0d op=%b z=%b pc_en got=%b exp=%b", n, op, z, o.pcen, e.pcen); end
      total++; if (o.ill !== e.ill) begin bad++; $display("FAIL rand n=%0d op=%b fn=%b illegal got=%b exp=%b", n, op, fn, o.ill, e.ill); end
      total++; if (o.m2r !== e.m2r || o.rdst !== e.rdst) begin bad++; $display("FAIL rand n=%0d op=%b m2r/rdst got=%b/%b exp=%b/%b", n, op, o.m2r, o.rdst, e.m2r, e.rdst); end
      total++; if (o.cnt1 !== m_count) begin bad++; $display("FAIL rand n=%0d count got=%0d exp=%0d", n, o.cnt1, m_count); end
      if (e.len >= 3) begin
        total++; if (o.alu3 !== e.alu3 || o.pcsrc3 !== e.pcsrc3) begin bad++; $display("FAIL rand n=%0d op=%b fn=%b alu/pcsrc got=%b/%b exp=%b/%b", n, op, fn, o.alu3, o.pcsrc3, e.alu3, e.pcsrc3); end
      end
      if (is_legal_op(op)) m_count++;
    end
  endtask

  task automatic test_final;
    @(negedge clk);
    total++; if (dbg_state !== S_FETCH) begin bad++; $display("FAIL final state got=%0d exp=%0d", dbg_state, S_FETCH); end
    total++; if (instr_count !== m_count) begin bad++; $display("FAIL final count got=%0d exp=%0d", instr_count, m_count); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_illegal_op();
    test_reset_mid();
`ifdef MCTRL_MEM_WAIT_EN
    test_mem_wait();
`endif
    test_random();
    test_final();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
